// File: rtl/mux_scan_nx1_if.sv
// mux_scan_nx1_if: channel bus, select controls and status strobes of the scanning mux
interface mux_scan_nx1_if #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 4
);
    localparam int SW = $clog2(CHANNELS);
    logic                      mode;
    logic                      hold;
    logic [SW-1:0]             sel_in;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [WIDTH-1:0]          data_out;
    logic [SW-1:0]             sel_out;
    logic                      valid;
    logic                      wrap;
    logic                      err;
    modport master (
        output mode, hold, sel_in, data_in,
        input  data_out, sel_out, valid, wrap, err
    );
    modport slave (
        input  mode, hold, sel_in, data_in,
        output data_out, sel_out, valid, wrap, err
    );
endinterface

// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: registered N-to-1 mux with manual select and dwell-timed auto-scan
module mux_scan_nx1 #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 4,
    parameter int DWELL    = 4
) (
    input logic           clk,
    input logic           rst,
    mux_scan_nx1_if.slave bus
);
    localparam int SW = $clog2(CHANNELS);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [SW:0]   CH    = (SW+1)'(CHANNELS);
    localparam logic [SW-1:0] LAST  = SW'(CHANNELS - 1);
    localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);
    logic [SW-1:0]    sel_q, sel_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             mode_q, first, err_nx, wrap_nx;
    logic [WIDTH-1:0] chan [CHANNELS];
    always_comb
        for (int k = 0; k < CHANNELS; k++)
            chan[k] = bus.data_in[k*WIDTH +: WIDTH];
    // Priority: hold, manual, scan entry, scan dwell/advance
    always_comb begin
        sel_nx  = sel_q;
        cnt_nx  = cnt;
        err_nx  = 1'b0;
        wrap_nx = 1'b0;
        if (!bus.hold) begin
            if (!bus.mode) begin
                cnt_nx = '0;
                if ({1'b0, bus.sel_in} < CH)
                    sel_nx = bus.sel_in;
                else
                    err_nx = 1'b1;
            end else if (!mode_q) begin
                cnt_nx = '0;
            end else if (cnt != DLAST) begin
                cnt_nx = cnt + 1'b1;
            end else begin
                cnt_nx  = '0;
                sel_nx  = (sel_q == LAST) ? '0 : sel_q + 1'b1;
                wrap_nx = (sel_q == LAST);
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q        <= '0;
            cnt          <= '0;
            mode_q       <= 1'b0;
            first        <= 1'b1;
            bus.data_out <= '0;
            bus.valid    <= 1'b0;
            bus.wrap     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            sel_q        <= sel_nx;
            cnt          <= cnt_nx;
            mode_q       <= bus.mode;
            first        <= 1'b0;
            bus.data_out <= chan[sel_nx];
            bus.valid    <= first || (sel_nx != sel_q);
            bus.wrap     <= wrap_nx;
            bus.err      <= err_nx;
        end
    end
    assign bus.sel_out = sel_q;
endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1: directed checks of an 8-channel DWELL=4 mux and a 5-channel DWELL=1 mux
module tb_mux_scan_nx1;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    always #5 clk = ~clk;
    mux_scan_nx1_if #(.CHANNELS(8), .WIDTH(4)) i8 ();
    mux_scan_nx1_if #(.CHANNELS(5), .WIDTH(4)) i5 ();
    mux_scan_nx1 #(.CHANNELS(8), .WIDTH(4), .DWELL(4)) u8 (.clk(clk), .rst(rst), .bus(i8));
    mux_scan_nx1 #(.CHANNELS(5), .WIDTH(4), .DWELL(1)) u5 (.clk(clk), .rst(rst), .bus(i5));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk8(input string tag, input int sel, input int dat, input int vld, input int wrp);
        chk({tag, " sel_out"}, 32'(i8.sel_out), 32'(sel));
        chk({tag, " data_out"}, 32'(i8.data_out), 32'(dat));
        chk({tag, " valid"}, 32'(i8.valid), 32'(vld));
        chk({tag, " wrap"}, 32'(i8.wrap), 32'(wrp));
    endtask
    initial begin
        rst = 1'b1;
        i8.mode = 1'b0; i8.hold = 1'b0; i8.sel_in = '0; i8.data_in = 32'h76543210;
        i5.mode = 1'b0; i5.hold = 1'b0; i5.sel_in = '0; i5.data_in = 20'h43210;
        #12;
        chk8("reset", 0, 0, 0, 0);
        chk("reset err", 32'(i8.err), 0);
        rst = 1'b0;
        // Manual sweep: first edge gives valid, then one change per edge
        tick();
        chk8("man0", 0, 0, 1, 0);
        for (int i = 1; i < 8; i++) begin
            i8.sel_in = 3'(i);
            tick();
            chk8("man", i, i, 1, 0);
            chk("man err", 32'(i8.err), 0);
        end
        tick();
        chk8("man steady", 7, 7, 0, 0);
        // Mode transitions: enter scan at channel 5, full dwell, then back to manual
        i8.sel_in = 3'd5;
        tick();
        chk8("pre scan", 5, 5, 1, 0);
        i8.mode = 1'b1;
        tick();
        chk8("enter scan", 5, 5, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk8("dwell 5", 5, 5, 0, 0);
        end
        tick();
        chk8("step 6", 6, 6, 1, 0);
        i8.mode = 1'b0;
        i8.sel_in = 3'd1;
        tick();
        chk8("exit scan", 1, 1, 1, 0);
        // Reset mid-scan, asserted and released between edges
        i8.mode = 1'b1;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk8("mid rst", 0, 0, 0, 0);
        chk("mid rst err", 32'(i8.err), 0);
        #2 rst = 1'b0;
        // Scan from reset: 4 edges per channel, wrap on the 33rd edge
        for (int e = 1; e <= 42; e++) begin
            tick();
            chk8("scan", ((e - 1) / 4) % 8, ((e - 1) / 4) % 8,
                 (e == 1 || (e - 1) % 4 == 0) ? 1 : 0, (e == 33) ? 1 : 0);
        end
        // Hold at channel 2 mid-dwell while its data changes
        i8.hold = 1'b1;
        i8.data_in = 32'h76543A10;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) i8.data_in = 32'h76543B10;
            tick();
            chk8("hold", 2, (i < 5) ? 'hA : 'hB, 0, 0);
        end
        i8.hold = 1'b0;
        i8.data_in = 32'h76543210;
        tick();
        chk8("resume1", 2, 2, 0, 0);
        tick();
        chk8("resume2", 2, 2, 0, 0);
        tick();
        chk8("resume adv", 3, 3, 1, 0);
        // Hold on the dwell-expiry edge suppresses the advance
        for (int i = 0; i < 3; i++) tick();
        chk8("pre expiry", 3, 3, 0, 0);
        i8.hold = 1'b1;
        tick();
        chk8("hold expiry", 3, 3, 0, 0);
        i8.hold = 1'b0;
        tick();
        chk8("post expiry", 4, 4, 1, 0);
        // Five channels, DWELL=1: invalid manual select and 4->0 wrap
        i5.sel_in = 3'd3;
        tick();
        chk("c5 man sel", 32'(i5.sel_out), 3);
        chk("c5 man valid", 32'(i5.valid), 1);
        i5.sel_in = 3'd6;
        tick();
        chk("c5 bad err", 32'(i5.err), 1);
        chk("c5 bad sel", 32'(i5.sel_out), 3);
        chk("c5 bad data", 32'(i5.data_out), 3);
        chk("c5 bad valid", 32'(i5.valid), 0);
        i5.sel_in = 3'd4;
        tick();
        chk("c5 err clear", 32'(i5.err), 0);
        chk("c5 sel4", 32'(i5.sel_out), 4);
        i5.mode = 1'b1;
        i5.sel_in = 3'd6;
        tick();
        chk("c5 enter sel", 32'(i5.sel_out), 4);
        chk("c5 enter valid", 32'(i5.valid), 0);
        for (int k = 0; k < 11; k++) begin
            tick();
            chk("c5 scan sel", 32'(i5.sel_out), 32'(k % 5));
            chk("c5 scan data", 32'(i5.data_out), 32'(k % 5));
            chk("c5 scan valid", 32'(i5.valid), 1);
            chk("c5 scan wrap", 32'(i5.wrap), (k % 5 == 0) ? 1 : 0);
            chk("c5 scan err", 32'(i5.err), 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
